ex_commit_stage: RTL and testbench

- Pipeline register between the ALU (execute) and the memory/writeback stage.
- Captures the ALU result, destination register and branch outcome for each executed instruction.
- Holds results in a 2-entry skid buffer so the upstream ready is a registered signal.
- Turns a taken branch/jump into a one-cycle fetch redirect plus a flush of younger stages, and drops the one wrong-path instruction that arrives behind it.

---
 rtl/ex_commit_stage_if.sv | 37 +++
 rtl/ex_commit_stage.sv | 194 +++++++++++++++++++
 tb/tb_ex_commit_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_commit_stage_if.sv
// Execute-to-memory handshake bundle for ex_commit_stage: execute-side inputs,
// memory-side outputs and the fetch redirect/flush outputs.
interface ex_commit_stage_if #(
  parameter int PC_WIDTH = 32,
  parameter int RD_WIDTH = 5
);
  logic                ex_valid_i;
  logic                ex_ready_o;
  logic [31:0]         alu_result_i;
  logic [RD_WIDTH-1:0] rd_addr_i;
  logic                rd_wen_i;
  logic                is_branch_i;
  logic                branch_taken_i;
  logic [PC_WIDTH-1:0] branch_pc_i;
  logic                mem_valid_o;
  logic                mem_ready_i;
  logic [31:0]         mem_result_o;
  logic [RD_WIDTH-1:0] mem_rd_addr_o;
  logic                mem_rd_wen_o;
  logic                redirect_valid_o;
  logic [PC_WIDTH-1:0] redirect_pc_o;
  logic                flush_o;

  modport master (
    output ex_valid_i, alu_result_i, rd_addr_i, rd_wen_i, is_branch_i,
           branch_taken_i, branch_pc_i, mem_ready_i,
    input  ex_ready_o, mem_valid_o, mem_result_o, mem_rd_addr_o, mem_rd_wen_o,
           redirect_valid_o, redirect_pc_o, flush_o
  );

  modport slave (
    input  ex_valid_i, alu_result_i, rd_addr_i, rd_wen_i, is_branch_i,
           branch_taken_i, branch_pc_i, mem_ready_i,
    output ex_ready_o, mem_valid_o, mem_result_o, mem_rd_addr_o, mem_rd_wen_o,
           redirect_valid_o, redirect_pc_o, flush_o
  );
endinterface

// File: rtl/ex_commit_stage.sv
// Execute/commit pipeline register: 2-entry skid buffer plus taken-branch redirect FSM.
// Optional branch statistics counters are enabled with `define EX_BRANCH_PERF_EN.
module ex_commit_stage #(
  parameter int PC_WIDTH = 32,
  parameter int RD_WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ex_commit_stage_if.slave bus
`ifdef EX_BRANCH_PERF_EN
  ,
  output logic [31:0]      branch_cnt_o,
  output logic [31:0]      taken_cnt_o
`endif
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic                main_valid_r;
  logic                main_valid_s;
  logic [31:0]         main_result_r;
  logic [31:0]         main_result_s;
  logic [RD_WIDTH-1:0] main_rd_r;
  logic [RD_WIDTH-1:0] main_rd_s;
  logic                main_wen_r;
  logic                main_wen_s;

  logic                skid_valid_r;
  logic                skid_valid_s;
  logic [31:0]         skid_result_r;
  logic [31:0]         skid_result_s;
  logic [RD_WIDTH-1:0] skid_rd_r;
  logic [RD_WIDTH-1:0] skid_rd_s;
  logic                skid_wen_r;
  logic                skid_wen_s;

  logic                ex_ready_r;
  logic                ex_ready_s;
  logic                redirect_valid_r;
  logic                flush_r;
  logic                redirect_s;
  logic [PC_WIDTH-1:0] redirect_pc_r;
  logic [PC_WIDTH-1:0] redirect_pc_s;

  logic                transfer_s;
  logic                main_free_s;
  logic                taken_s;

  // Next-state logic for the buffer entries, the redirect FSM and the upstream ready.
  always_comb begin
    transfer_s    = bus.ex_valid_i & ex_ready_r & (state_r == ST_RUN);
    main_free_s   = ~main_valid_r | bus.mem_ready_i;
    taken_s       = transfer_s & bus.is_branch_i & bus.branch_taken_i;

    main_valid_s  = main_valid_r;
    main_result_s = main_result_r;
    main_rd_s     = main_rd_r;
    main_wen_s    = main_wen_r;
    skid_valid_s  = skid_valid_r;
    skid_result_s = skid_result_r;
    skid_rd_s     = skid_rd_r;
    skid_wen_s    = skid_wen_r;
    state_s       = state_r;
    redirect_s    = 1'b0;
    redirect_pc_s = redirect_pc_r;

    // A full skid forces ready low, so a transfer never coincides with a skid drain.
    if (main_free_s) begin
      if (skid_valid_r) begin
        main_valid_s  = 1'b1;
        main_result_s = skid_result_r;
        main_rd_s     = skid_rd_r;
        main_wen_s    = skid_wen_r;
        skid_valid_s  = 1'b0;
      end else if (transfer_s) begin
        main_valid_s  = 1'b1;
        main_result_s = bus.alu_result_i;
        main_rd_s     = bus.rd_addr_i;
        main_wen_s    = bus.rd_wen_i;
      end else begin
        main_valid_s  = 1'b0;
      end
    end else begin
      if (transfer_s) begin
        skid_valid_s  = 1'b1;
        skid_result_s = bus.alu_result_i;
        skid_rd_s     = bus.rd_addr_i;
        skid_wen_s    = bus.rd_wen_i;
      end else begin
        skid_valid_s  = skid_valid_r;
      end
    end

    case (state_r)
      ST_RUN: begin
        if (taken_s) begin
          state_s       = ST_REDIRECT;
          redirect_s    = 1'b1;
          redirect_pc_s = bus.branch_pc_i;
        end else begin
          state_s       = ST_RUN;
          redirect_s    = 1'b0;
        end
      end
      ST_REDIRECT: begin
        state_s    = ST_RUN;
        redirect_s = 1'b0;
      end
      default: begin
        state_s    = ST_RUN;
        redirect_s = 1'b0;
      end
    endcase

    // The wrong-path slot is swallowed, so ready is forced high during REDIRECT.
    if (state_s == ST_REDIRECT) begin
      ex_ready_s = 1'b1;
    end else begin
      ex_ready_s = ~skid_valid_s;
    end
  end

  // State registers for the buffer, FSM and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r          <= ST_RUN;
      main_valid_r     <= 1'b0;
      main_result_r    <= 32'h0000_0000;
      main_rd_r        <= {RD_WIDTH{1'b0}};
      main_wen_r       <= 1'b0;
      skid_valid_r     <= 1'b0;
      skid_result_r    <= 32'h0000_0000;
      skid_rd_r        <= {RD_WIDTH{1'b0}};
      skid_wen_r       <= 1'b0;
      ex_ready_r       <= 1'b0;
      redirect_valid_r <= 1'b0;
      flush_r          <= 1'b0;
      redirect_pc_r    <= {PC_WIDTH{1'b0}};
    end else begin
      state_r          <= state_s;
      main_valid_r     <= main_valid_s;
      main_result_r    <= main_result_s;
      main_rd_r        <= main_rd_s;
      main_wen_r       <= main_wen_s;
      skid_valid_r     <= skid_valid_s;
      skid_result_r    <= skid_result_s;
      skid_rd_r        <= skid_rd_s;
      skid_wen_r       <= skid_wen_s;
      ex_ready_r       <= ex_ready_s;
      redirect_valid_r <= redirect_s;
      flush_r          <= redirect_s;
      redirect_pc_r    <= redirect_pc_s;
    end
  end

  assign bus.ex_ready_o       = ex_ready_r;
  assign bus.mem_valid_o      = main_valid_r;
  assign bus.mem_result_o     = main_result_r;
  assign bus.mem_rd_addr_o    = main_rd_r;
  assign bus.mem_rd_wen_o     = main_wen_r;
  assign bus.redirect_valid_o = redirect_valid_r;
  assign bus.redirect_pc_o    = redirect_pc_r;
  assign bus.flush_o          = flush_r;

`ifdef EX_BRANCH_PERF_EN
  logic [31:0] branch_cnt_r;
  logic [31:0] taken_cnt_r;

  // Branch statistics; only accepted instructions count, so wrong-path slots are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_r <= 32'h0000_0000;
      taken_cnt_r  <= 32'h0000_0000;
    end else begin
      if (transfer_s & bus.is_branch_i) begin
        branch_cnt_r <= branch_cnt_r + 32'h0000_0001;
      end
      if (taken_s) begin
        taken_cnt_r <= taken_cnt_r + 32'h0000_0001;
      end
    end
  end

  assign branch_cnt_o = branch_cnt_r;
  assign taken_cnt_o  = taken_cnt_r;
`endif

endmodule

// File: tb/tb_ex_commit_stage.sv
// Self-checking bench for ex_commit_stage: directed vector table, mid-stream reset,
// and randomized traffic compared against a queue-based reference model.
module tb_ex_commit_stage;
  localparam int PC_WIDTH = 32;
  localparam int RD_WIDTH = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_commit_stage_if #(.PC_WIDTH(PC_WIDTH), .RD_WIDTH(RD_WIDTH)) bus ();

`ifdef EX_BRANCH_PERF_EN
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;
`endif

  ex_commit_stage #(.PC_WIDTH(PC_WIDTH), .RD_WIDTH(RD_WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef EX_BRANCH_PERF_EN
    ,
    .branch_cnt_o (branch_cnt),
    .taken_cnt_o  (taken_cnt)
`endif
  );

  int total = 0;
  int passed = 0;

  // Reference model: buffer contents as an in-order queue of at most two entries.
  typedef struct packed {
    logic [31:0]         res;
    logic [RD_WIDTH-1:0] rd;
    logic                wen;
  } entry_t;

  entry_t      m_q[$];
  bit          m_redir;
  bit          m_fresh;
  logic [31:0] m_pc;
`ifdef EX_BRANCH_PERF_EN
  logic [31:0] m_bcnt;
  logic [31:0] m_tcnt;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        br;
    logic        tk;
    logic [31:0] bpc;
    logic        mrdy;
    logic        e_valid;
    logic [31:0] e_res;
    logic        e_ready;
    logic        e_redir;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit exp_ready();
    return !m_fresh && (m_redir || m_q.size() < 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_redir = 1'b0;
    m_fresh = 1'b1;
    m_pc    = 32'h0;
`ifdef EX_BRANCH_PERF_EN
    m_bcnt  = 32'h0;
    m_tcnt  = 32'h0;
`endif
  endtask

  task automatic model_update();
    bit     acc;
    bit     new_redir;
    entry_t e;
    acc       = bus.ex_valid_i && exp_ready() && !m_redir;
    new_redir = acc && bus.is_branch_i && bus.branch_taken_i;
    if (m_q.size() > 0 && bus.mem_ready_i) void'(m_q.pop_front());
    if (acc) begin
      e.res = bus.alu_result_i;
      e.rd  = bus.rd_addr_i;
      e.wen = bus.rd_wen_i;
      m_q.push_back(e);
`ifdef EX_BRANCH_PERF_EN
      if (bus.is_branch_i) m_bcnt = m_bcnt + 32'h1;
      if (new_redir) m_tcnt = m_tcnt + 32'h1;
`endif
    end
    if (new_redir) m_pc = bus.branch_pc_i;
    m_redir = new_redir;
    m_fresh = 1'b0;
  endtask

  task automatic check_model();
    chk("ex_ready", {63'h0, bus.ex_ready_o}, {63'h0, exp_ready()});
    chk("mem_valid", {63'h0, bus.mem_valid_o}, {63'h0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      chk("mem_result", {32'h0, bus.mem_result_o}, {32'h0, m_q[0].res});
      chk("mem_rd", {59'h0, bus.mem_rd_addr_o}, {59'h0, m_q[0].rd});
      chk("mem_wen", {63'h0, bus.mem_rd_wen_o}, {63'h0, m_q[0].wen});
    end
    chk("redirect_valid", {63'h0, bus.redirect_valid_o}, {63'h0, m_redir});
    chk("flush", {63'h0, bus.flush_o}, {63'h0, m_redir});
    chk("redirect_pc", {32'h0, bus.redirect_pc_o}, {32'h0, m_pc});
`ifdef EX_BRANCH_PERF_EN
    chk("branch_cnt", {32'h0, branch_cnt}, {32'h0, m_bcnt});
    chk("taken_cnt", {32'h0, taken_cnt}, {32'h0, m_tcnt});
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic wen, input logic br, input logic tk,
                       input logic [31:0] bpc, input logic mrdy);
    bus.ex_valid_i     = v;
    bus.alu_result_i   = res;
    bus.rd_addr_i      = rd;
    bus.rd_wen_i       = wen;
    bus.is_branch_i    = br;
    bus.branch_taken_i = tk;
    bus.branch_pc_i    = bpc;
    bus.mem_ready_i    = mrdy;
  endtask

  // One clock: the model advances on the edge, outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ex_ready", {63'h0, bus.ex_ready_o}, 64'h0);
    chk("rst_mem_valid", {63'h0, bus.mem_valid_o}, 64'h0);
    chk("rst_mem_result", {32'h0, bus.mem_result_o}, 64'h0);
    chk("rst_mem_rd", {59'h0, bus.mem_rd_addr_o}, 64'h0);
    chk("rst_mem_wen", {63'h0, bus.mem_rd_wen_o}, 64'h0);
    chk("rst_redirect_valid", {63'h0, bus.redirect_valid_o}, 64'h0);
    chk("rst_redirect_pc", {32'h0, bus.redirect_pc_o}, 64'h0);
    chk("rst_flush", {63'h0, bus.flush_o}, 64'h0);
`ifdef EX_BRANCH_PERF_EN
    chk("rst_branch_cnt", {32'h0, branch_cnt}, 64'h0);
    chk("rst_taken_cnt", {32'h0, taken_cnt}, 64'h0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] res, input logic [4:0] rd,
                              input logic br, input logic tk, input logic [31:0] bpc,
                              input logic mrdy, input logic ev, input logic [31:0] eres,
                              input logic erdy, input logic eredir);
    vec_t t;
    t.valid = v; t.res = res; t.rd = rd; t.br = br; t.tk = tk; t.bpc = bpc;
    t.mrdy = mrdy; t.e_valid = ev; t.e_res = eres; t.e_ready = erdy; t.e_redir = eredir;
    return t;
  endfunction

  initial begin
`ifdef EX_BRANCH_PERF_EN
    logic [31:0] b0;
    logic [31:0] t0;
`endif
    // Fields: valid res rd br tk bpc mrdy | exp valid, result, ready, redirect
    tbl[0]  = mk(1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 32'h11,  5'd1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h11,  1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 32'h22,  5'd2, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h22,  1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 32'h33,  5'd3, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h33,  1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 32'h44,  5'd4, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 32'h11,  5'd1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h11,  1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 32'h22,  5'd2, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h11,  1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 32'h33,  5'd3, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h11,  1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 32'h33,  5'd3, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h22,  1'b1, 1'b0);
    tbl[10] = mk(1'b1, 32'h33,  5'd3, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h33,  1'b1, 1'b0);
    tbl[11] = mk(1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0);
    tbl[12] = mk(1'b1, 32'h104, 5'd1, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h104, 1'b1, 1'b1);
    tbl[13] = mk(1'b1, 32'h555, 5'd3, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0);
    tbl[14] = mk(1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0);
    tbl[15] = mk(1'b1, 32'h66,  5'd4, 1'b1, 1'b0, 32'h400, 1'b1, 1'b1, 32'h66,  1'b1, 1'b0);
    tbl[16] = mk(1'b1, 32'h77,  5'd5, 1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 32'h77,  1'b1, 1'b0);
    tbl[17] = mk(1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0);

    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].valid, tbl[i].res, tbl[i].rd, 1'b1, tbl[i].br, tbl[i].tk,
            tbl[i].bpc, tbl[i].mrdy);
      step();
      chk($sformatf("vec%0d_valid", i), {63'h0, bus.mem_valid_o}, {63'h0, tbl[i].e_valid});
      if (tbl[i].e_valid) chk($sformatf("vec%0d_result", i), {32'h0, bus.mem_result_o},
                              {32'h0, tbl[i].e_res});
      chk($sformatf("vec%0d_ready", i), {63'h0, bus.ex_ready_o}, {63'h0, tbl[i].e_ready});
      chk($sformatf("vec%0d_redirect", i), {63'h0, bus.redirect_valid_o},
          {63'h0, tbl[i].e_redir});
    end
    chk("jal_redirect_pc_held", {32'h0, bus.redirect_pc_o}, 64'h200);

    // Fill both entries (second one a taken branch) then reset asynchronously.
    drive(1'b1, 32'hA1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 32'hA2, 5'd7, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
    step();
    chk("full_before_reset", {63'h0, bus.ex_ready_o}, 64'h1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle", {63'h0, bus.mem_valid_o}, 64'h0);
    end

`ifdef EX_BRANCH_PERF_EN
    b0 = branch_cnt;
    t0 = taken_cnt;
    drive(1'b1, 32'h10, 5'd1, 1'b1, 1'b1, 1'b1, 32'h600, 1'b1);
    step();
    drive(1'b1, 32'h20, 5'd2, 1'b1, 1'b1, 1'b1, 32'h700, 1'b1);
    step();
    drive(1'b1, 32'h30, 5'd3, 1'b1, 1'b1, 1'b0, 32'h800, 1'b1);
    step();
    drive(1'b1, 32'h40, 5'd4, 1'b1, 1'b1, 1'b1, 32'h900, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("perf_branch_delta", {32'h0, branch_cnt - b0}, 64'd3);
    chk("perf_taken_delta", {32'h0, taken_cnt - t0}, 64'd2);
`endif

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99) < 70, $urandom, 5'($urandom), 1'($urandom),
            $urandom_range(99) < 25, 1'($urandom), $urandom,
            $urandom_range(99) < 60);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
